// File: rtl/fp_div_iter.sv
// fp_div_iter: multi-cycle radix-2 restoring floating-point divider.
// One quotient bit per clock, round-to-nearest-even, flush-to-zero for subnormals,
// valid/ready handshakes on both sides, and IEEE-style exception flags.
module fp_div_iter #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] opA,
  input  logic [EXP_W+MAN_W:0] opB,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] quotient,
  output logic                 dbz,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 inexact,
  output logic                 invalid
);

  localparam int N       = MAN_W + 3;
  localparam int CW      = $clog2(N);
  localparam int EW2     = EXP_W + 2;
  localparam int BIAS    = (1 << (EXP_W - 1)) - 1;
  localparam int EXP_MAX = (1 << EXP_W) - 1;

  localparam logic signed [EW2-1:0] BiasS   = EW2'(BIAS);
  localparam logic signed [EW2-1:0] ExpMaxS = EW2'(EXP_MAX);
  localparam logic signed [EW2-1:0] OneS    = EW2'(1);

  typedef enum logic [1:0] {StIdle, StCalc, StRound, StDone} stateT;

  stateT                  state;
  logic [MAN_W+1:0]       remR;
  logic [MAN_W+1:0]       divD;
  logic [N-1:0]           qReg;
  logic [CW-1:0]          cnt;
  logic signed [EW2-1:0]  expBase;
  logic                   qSign;

  // Operand fields and classification
  logic                   sA, sB;
  logic [EXP_W-1:0]       eA, eB;
  logic [MAN_W-1:0]       mA, mB;
  logic                   aZero, aInf, aNan, bZero, bInf, bNan;

  assign {sA, eA, mA} = opA;
  assign {sB, eB, mB} = opB;

  assign aZero = (eA == '0);
  assign aInf  = (eA == '1) && (mA == '0);
  assign aNan  = (eA == '1) && (mA != '0);
  assign bZero = (eB == '0);
  assign bInf  = (eB == '1) && (mB == '0);
  assign bNan  = (eB == '1) && (mB != '0);

  assign in_ready  = (state == StIdle) || ((state == StDone) && out_ready);
  assign out_valid = (state == StDone);

  logic accept;
  assign accept = in_valid && in_ready;

  // Special-case result decode, in priority order
  logic                 specHit, specDbz, specInv;
  logic [EXP_W+MAN_W:0] specResult;

  always_comb begin
    specHit    = 1'b1;
    specDbz    = 1'b0;
    specInv    = 1'b0;
    specResult = {sA ^ sB, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    if (aNan || bNan || (aZero && bZero) || (aInf && bInf)) begin
      specResult = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      specInv    = 1'b1;
    end else if (bZero && !aInf) begin
      specDbz = 1'b1;
    end else if (aInf) begin
      specDbz = 1'b0;
    end else if (aZero || bInf) begin
      specResult = {sA ^ sB, {(EXP_W+MAN_W){1'b0}}};
    end else begin
      specHit = 1'b0;
    end
  end

  // One restoring-division step on the current partial remainder
  logic             qBit;
  logic [MAN_W+1:0] remSub;

  always_comb begin
    qBit   = (remR >= divD);
    remSub = qBit ? (remR - divD) : remR;
  end

  // Normalise, round to nearest even and detect overflow/underflow
  logic                  intBit, guardBit, stickyBit, roundUp;
  logic [MAN_W:0]        sig;
  logic [MAN_W+1:0]      sigRnd;
  logic [MAN_W-1:0]      manRnd;
  logic signed [EW2-1:0] expRnd;
  logic                  rndOvf, rndUnf, rndInexact;
  logic [EXP_W+MAN_W:0]  rndResult;

  always_comb begin
    intBit     = qReg[N-1];
    sig        = intBit ? qReg[N-1:2] : qReg[N-2:1];
    guardBit   = intBit ? qReg[1] : qReg[0];
    stickyBit  = (intBit & qReg[0]) | (remR != '0);
    roundUp    = guardBit & (stickyBit | sig[0]);
    sigRnd     = {1'b0, sig} + {{(MAN_W+1){1'b0}}, roundUp};
    expRnd     = intBit ? expBase : (expBase - OneS);
    manRnd     = sigRnd[MAN_W-1:0];
    if (sigRnd[MAN_W+1]) begin
      // Rounding carried out: significand becomes 1.000..., bump the exponent
      expRnd = expRnd + OneS;
      manRnd = sigRnd[MAN_W:1];
    end
    rndOvf     = (expRnd >= ExpMaxS);
    rndUnf     = expRnd[EW2-1] || (expRnd == '0);
    rndInexact = guardBit | stickyBit | rndOvf | rndUnf;
    rndResult  = {qSign, expRnd[EXP_W-1:0], manRnd};
    if (rndOvf) begin
      rndResult = {qSign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (rndUnf) begin
      rndResult = {qSign, {(EXP_W+MAN_W){1'b0}}};
    end
  end

  // Control FSM with registered quotient and flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      remR      <= '0;
      divD      <= '0;
      qReg      <= '0;
      cnt       <= '0;
      expBase   <= '0;
      qSign     <= 1'b0;
      quotient  <= '0;
      dbz       <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
      invalid   <= 1'b0;
    end else if (accept) begin
      dbz       <= specDbz;
      invalid   <= specInv;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
      if (specHit) begin
        quotient <= specResult;
        state    <= StDone;
      end else begin
        remR    <= {1'b0, 1'b1, mA};
        divD    <= {1'b0, 1'b1, mB};
        qReg    <= '0;
        cnt     <= CW'(N - 1);
        expBase <= $signed({2'b00, eA}) - $signed({2'b00, eB}) + BiasS;
        qSign   <= sA ^ sB;
        state   <= StCalc;
      end
    end else begin
      case (state)
        StCalc: begin
          remR <= {remSub[MAN_W:0], 1'b0};
          qReg <= {qReg[N-2:0], qBit};
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= StRound;
          end
        end
        StRound: begin
          quotient  <= rndResult;
          overflow  <= rndOvf;
          underflow <= rndUnf;
          inexact   <= rndInexact;
          state     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_iter.sv
// Self-checking bench for fp_div_iter: directed half-precision cases plus random
// half- and single-precision operands against an integer-arithmetic RNE model.
module tb_fp_div_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Half-precision instance
  logic        hInValid = 1'b0, hOutReady = 1'b0;
  logic [15:0] hOpA = '0, hOpB = '0;
  logic        hInReady, hOutValid;
  logic [15:0] hQuot;
  logic        hDbz, hOvf, hUnf, hInx, hInv;

  // Single-precision instance
  logic        sInValid = 1'b0, sOutReady = 1'b0;
  logic [31:0] sOpA = '0, sOpB = '0;
  logic        sInReady, sOutValid;
  logic [31:0] sQuot;
  logic        sDbz, sOvf, sUnf, sInx, sInv;

  fp_div_iter #(.EXP_W(5), .MAN_W(10)) dutHalf (
    .clock(clk), .reset(rst), .in_valid(hInValid), .in_ready(hInReady),
    .opA(hOpA), .opB(hOpB), .out_valid(hOutValid), .out_ready(hOutReady),
    .quotient(hQuot), .dbz(hDbz), .overflow(hOvf), .underflow(hUnf),
    .inexact(hInx), .invalid(hInv)
  );

  fp_div_iter #(.EXP_W(8), .MAN_W(23)) dutSingle (
    .clock(clk), .reset(rst), .in_valid(sInValid), .in_ready(sInReady),
    .opA(sOpA), .opB(sOpB), .out_valid(sOutValid), .out_ready(sOutReady),
    .quotient(sQuot), .dbz(sDbz), .overflow(sOvf), .underflow(sUnf),
    .inexact(sInx), .invalid(sInv)
  );

  int checks = 0;
  int failures = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference model: returns {invalid, inexact, underflow, overflow, dbz, result[63:0]}
  function automatic logic [68:0] refDiv(input int ew, input int mw,
                                         input logic [63:0] a, input logic [63:0] b);
    longint unsigned one = 1;
    longint unsigned expMax, mA, mB, eA, eB, num, qq, rem, sig, manMask, signBit, res;
    longint e;
    int sh;
    bit sA, sB, g, st, aZ, aI, aN, bZ, bI, bN;
    bit fInv, fInx, fUnf, fOvf, fDbz;
    expMax  = (one << ew) - 1;
    manMask = (one << mw) - 1;
    mA = a & manMask;  eA = (a >> mw) & expMax;  sA = a[ew+mw];
    mB = b & manMask;  eB = (b >> mw) & expMax;  sB = b[ew+mw];
    aZ = (eA == 0); aI = (eA == expMax) && (mA == 0); aN = (eA == expMax) && (mA != 0);
    bZ = (eB == 0); bI = (eB == expMax) && (mB == 0); bN = (eB == expMax) && (mB != 0);
    signBit = longint'(sA ^ sB) << (ew + mw);
    {fInv, fInx, fUnf, fOvf, fDbz} = '0;
    if (aN || bN || (aZ && bZ) || (aI && bI)) begin
      res = (expMax << mw) | (one << (mw - 1));
      fInv = 1;
    end else if (bZ && !aI) begin
      res = signBit | (expMax << mw);
      fDbz = 1;
    end else if (aI) begin
      res = signBit | (expMax << mw);
    end else if (aZ || bI) begin
      res = signBit;
    end else begin
      mA  = mA | (one << mw);
      mB  = mB | (one << mw);
      num = mA << (mw + 2);
      qq  = num / mB;
      rem = num % mB;
      e   = longint'(eA) - longint'(eB) + ((longint'(1) << (ew - 1)) - 1);
      if (qq >= (one << (mw + 2))) sh = 2;
      else begin
        sh = 1;
        e  = e - 1;
      end
      sig = qq >> sh;
      g   = ((qq >> (sh - 1)) & 1) != 0;
      st  = ((qq & ((one << (sh - 1)) - 1)) != 0) || (rem != 0);
      fInx = g || st;
      if (g && (st || sig[0])) sig = sig + 1;
      if (sig == (one << (mw + 1))) begin
        sig = sig >> 1;
        e   = e + 1;
      end
      if (e >= longint'(expMax)) begin
        res = signBit | (expMax << mw);
        fOvf = 1;
        fInx = 1;
      end else if (e <= 0) begin
        res = signBit;
        fUnf = 1;
        fInx = 1;
      end else begin
        res = signBit | (longint'(e) << mw) | (sig & manMask);
      end
    end
    return {fInv, fInx, fUnf, fOvf, fDbz, res};
  endfunction

  // Issue one operation with out_ready=1 and collect result, flags and latency in edges
  task automatic runOp(input bit wide, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic [4:0] flg, output int lat);
    int guard;
    @(negedge clk);
    if (wide) begin sOpA = a; sOpB = b; sInValid = 1'b1; sOutReady = 1'b1; end
    else begin hOpA = a[15:0]; hOpB = b[15:0]; hInValid = 1'b1; hOutReady = 1'b1; end
    guard = 0;
    while (!(wide ? sInReady : hInReady) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    res = '0; flg = '0; lat = -1;
    if (!(wide ? sInReady : hInReady)) begin
      checkVal("acceptTimeout", 0, 1);
      hInValid = 1'b0; sInValid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    hInValid = 1'b0; sInValid = 1'b0;
    lat = 1;
    while (!(wide ? sOutValid : hOutValid) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!(wide ? sOutValid : hOutValid)) begin
      checkVal("resultTimeout", 0, 1);
      return;
    end
    if (wide) begin res = sQuot; flg = {sInv, sInx, sUnf, sOvf, sDbz}; end
    else begin res = {16'h0, hQuot}; flg = {hInv, hInx, hUnf, hOvf, hDbz}; end
  endtask

  typedef struct {
    string       tag;
    logic [15:0] a, b, q;
    logic [4:0]  f;
    int          lat;
  } dirT;

  dirT dirs[$] = '{
    '{"div6by2",   16'h4600, 16'h4000, 16'h4200, 5'b00000, 15},
    '{"div1by3",   16'h3C00, 16'h4200, 16'h3555, 5'b01000, 15},
    '{"div1byM3",  16'h3C00, 16'hC200, 16'hB555, 5'b01000, 15},
    '{"divByZero", 16'hC000, 16'h0000, 16'hFC00, 5'b00001, 1},
    '{"zeroZero",  16'h0000, 16'h0000, 16'h7E00, 5'b10000, 1},
    '{"infInf",    16'h7C00, 16'h7C00, 16'h7E00, 5'b10000, 1},
    '{"overflow",  16'h7BFF, 16'h3800, 16'h7C00, 5'b01010, 15},
    '{"underflow", 16'h0400, 16'h4000, 16'h0000, 5'b01100, 15}
  };

  initial begin
    logic [31:0] res, a, b;
    logic [4:0]  flg;
    logic [68:0] want;
    int          lat, guard;

    // Reset state
    repeat (3) @(negedge clk);
    checkVal("rstOutValid", hOutValid, 0);
    checkVal("rstInReady", hInReady, 1);
    checkVal("rstQuot", hQuot, 0);
    checkVal("rstFlags", {hInv, hInx, hUnf, hOvf, hDbz}, 0);
    checkVal("rstSingleQuot", sQuot, 0);
    rst = 1'b0;

    // Directed half-precision cases
    foreach (dirs[i]) begin
      runOp(1'b0, {16'h0, dirs[i].a}, {16'h0, dirs[i].b}, res, flg, lat);
      checkVal({dirs[i].tag, "_q"}, res[15:0], dirs[i].q);
      checkVal({dirs[i].tag, "_flags"}, flg, dirs[i].f);
      checkVal({dirs[i].tag, "_lat"}, lat, dirs[i].lat);
    end

    // Backpressure: hold out_ready low, then accept the next op in the releasing cycle
    @(negedge clk);
    hOpA = 16'h4600; hOpB = 16'h4000; hInValid = 1'b1; hOutReady = 1'b0;
    @(posedge clk);
    @(negedge clk);
    hInValid = 1'b0;
    guard = 0;
    while (!hOutValid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkVal("stallGotValid", hOutValid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkVal("stallHoldQ", hQuot, 16'h4200);
      checkVal("stallValid", hOutValid, 1);
      checkVal("stallReady", hInReady, 0);
    end
    hOpA = 16'h3C00; hOpB = 16'h4200; hInValid = 1'b1; hOutReady = 1'b1;
    #1;
    checkVal("releaseReady", hInReady, 1);
    @(posedge clk);
    @(negedge clk);
    hInValid = 1'b0;
    checkVal("secondAcceptValid", hOutValid, 0);
    checkVal("secondAcceptReady", hInReady, 0);
    guard = 0;
    while (!hOutValid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkVal("secondResult", hQuot, 16'h3555);
    checkVal("secondInexact", hInx, 1);

    // Reset in the middle of CALC
    @(negedge clk);
    hOpA = 16'h4600; hOpB = 16'h4000; hInValid = 1'b1; hOutReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hInValid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkVal("midRstValid", hOutValid, 0);
    checkVal("midRstReady", hInReady, 1);
    checkVal("midRstQuot", hQuot, 0);
    rst = 1'b0;
    runOp(1'b0, 32'h4600, 32'h4000, res, flg, lat);
    checkVal("postRst_q", res[15:0], 16'h4200);
    checkVal("postRst_lat", lat, 15);

    // Random half-precision operands, specials included
    for (int i = 0; i < 150; i++) begin
      a = {16'h0, 16'($urandom)};
      b = {16'h0, 16'($urandom)};
      runOp(1'b0, a, b, res, flg, lat);
      want = refDiv(5, 10, {32'h0, a}, {32'h0, b});
      checkVal("randHalf_q", res[15:0], want[15:0]);
      checkVal("randHalf_flags", flg, want[68:64]);
    end

    // Random single-precision normal operands
    for (int i = 0; i < 150; i++) begin
      a[31] = 1'($urandom_range(0, 1));
      a[30:23] = 8'($urandom_range(1, 254));
      a[22:0] = 23'($urandom);
      b[31] = 1'($urandom_range(0, 1));
      b[30:23] = 8'($urandom_range(64, 190));
      b[22:0] = 23'($urandom);
      runOp(1'b1, a, b, res, flg, lat);
      want = refDiv(8, 23, {32'h0, a}, {32'h0, b});
      checkVal("randSingle_q", res, want[31:0]);
      checkVal("randSingle_flags", flg, want[68:64]);
      if (i == 0) checkVal("single_lat", lat, 28);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
